// File: rtl/arb_mux.sv
// arb_mux: N-channel valid/ready arbiter-mux (fixed-select or round-robin) with a one-deep registered output.
// Ports: clk; rst (async, active-high); in_data/in_valid/in_ready per channel;
//        mode (0 fixed-select, 1 round-robin); sel (channel index for fixed-select);
//        out_data/out_valid/out_ready/out_chan registered output stage.
// Optional: define ARB_MUX_SEL_ERR_EN to add sticky sel_err (fixed-select with out-of-range sel and valid input).
module arb_mux #(
    parameter int WIDTH = 32,
    parameter int N = 4,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_chan
`ifdef ARB_MUX_SEL_ERR_EN
    ,
    output logic               sel_err
`endif
);
    logic [SEL_W-1:0] ptr, gidx, idx;
    logic             found, load, sel_ok;
    logic [WIDTH-1:0] gdata;

    assign load   = !out_valid | out_ready;
    assign sel_ok = int'(sel) < N;

    // Round-robin search starts one past the last granted channel and wraps.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        if (mode) begin
            for (int k = 1; k <= N; k++) begin
                idx = SEL_W'((int'(ptr) + k) % N);
                if (!found && in_valid[idx]) begin
                    found = 1'b1;
                    gidx  = idx;
                end
            end
        end else if (sel_ok && in_valid[sel]) begin
            found = 1'b1;
            gidx  = sel;
        end
    end

    always_comb begin
        gdata = '0;
        for (int i = 0; i < N; i++)
            if (SEL_W'(i) == gidx) gdata = in_data[i*WIDTH +: WIDTH];
    end

    // rst gating keeps in_ready low even though load is high while the register is cleared.
    assign in_ready = (found && load && !rst) ? (N'(1) << gidx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= SEL_W'(N - 1);
        end else if (load) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_chan  <= gidx;
                ptr       <= gidx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ARB_MUX_SEL_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_err <= 1'b0;
        else if (!mode && !sel_ok && |in_valid) sel_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: table vectors, hand sequences and a randomized reference model for arb_mux.
module tb_arb_mux;
    logic        clk, rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic        mode, out_valid, out_ready;
    logic [1:0]  sel, out_chan;
    logic [7:0]  out_data;
`ifdef ARB_MUX_SEL_ERR_EN
    logic        sel_err, se3;
`endif
    logic [23:0] d3;
    logic [2:0]  v3, r3;
    logic [1:0]  s3, c3;
    logic        m3, ov3, or3;
    logic [7:0]  od3;

    int vectors = 0;
    int miscompares = 0;

    arb_mux #(.WIDTH(8), .N(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_chan(out_chan)
`ifdef ARB_MUX_SEL_ERR_EN
        , .sel_err(sel_err)
`endif
    );

    arb_mux #(.WIDTH(8), .N(3)) u3 (
        .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(r3),
        .mode(m3), .sel(s3), .out_data(od3), .out_valid(ov3),
        .out_ready(or3), .out_chan(c3)
`ifdef ARB_MUX_SEL_ERR_EN
        , .sel_err(se3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: arbitration rules evaluated directly on abstract state.
    logic       m_ov;
    logic [7:0] m_data;
    int         m_chan, m_ptr;

    task automatic model_step();
        int   g;
        logic ld;
        ld = !m_ov || out_ready;
        g  = -1;
        if (mode) begin
            for (int k = 1; k <= 4; k++)
                if (g < 0 && in_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end else if (in_valid[sel]) begin
            g = int'(sel);
        end
        chk("rnd_ready", 32'(in_ready), (ld && g >= 0) ? (32'd1 << g) : 32'd0);
        chk("rnd_valid", 32'(out_valid), 32'(m_ov));
        chk("rnd_data", 32'(out_data), 32'(m_data));
        if (m_ov) chk("rnd_chan", 32'(out_chan), 32'(m_chan));
        if (ld) begin
            if (g >= 0) begin
                m_ov   = 1'b1;
                m_data = in_data[g*8 +: 8];
                m_chan = g;
                m_ptr  = g;
            end else begin
                m_ov = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic       md;
        logic [1:0] sl;
        logic [3:0] v;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] ch;
        logic [7:0] d;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // round-robin, all valid: 0,1,2,3,0
        tbl[0]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00};
        tbl[1]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 8'h11};
        tbl[2]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 8'h22};
        tbl[3]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd2, 8'h33};
        tbl[4]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd3, 8'h44};
        tbl[5]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 8'h11};
        // fixed select sel=2
        tbl[6]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 8'h22};
        tbl[7]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33};
        tbl[8]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33};
        // round-robin with channels 1 and 3 valid
        tbl[9]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd2, 8'h33};
        tbl[10] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd3, 8'h44};
        tbl[11] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd1, 8'h22};
        tbl[12] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd3, 8'h44};
        tbl[13] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd1, 8'h22};
        // drain: no valid, output empties and data holds
        tbl[14] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b1, 2'd3, 8'h44};
        tbl[15] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h44};

        rst = 1'b1;
        in_data = 32'h44332211; in_valid = 4'hF; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
        d3 = 24'h332211; v3 = 3'b000; s3 = 2'd0; m3 = 1'b0; or3 = 1'b1;

        // reset state
        @(negedge clk); #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_chan", 32'(out_chan), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_valid3", 32'(ov3), 32'd0);
        in_valid = 4'h0;
        rst = 1'b0;
        m_ov = 1'b0; m_data = 8'h00; m_chan = 0; m_ptr = 3;

        // randomized against the model
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            out_ready = ($urandom % 4) != 0;
            in_data   = $urandom;
            #1;
            model_step();
        end

        // table vectors; first row is driven at the release edge
        in_valid = 4'h0; in_data = 32'h44332211;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mode = tbl[i].md; sel = tbl[i].sl; in_valid = tbl[i].v; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_chan", i), 32'(out_chan), 32'(tbl[i].ch));
            chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].d));
            @(negedge clk);
        end

        // backpressure hold of 0x5A, then same-cycle accept
        mode = 1'b0; sel = 2'd0; in_data[7:0] = 8'h5A; in_valid = 4'b0001; out_ready = 1'b1;
        #1 chk("bp_first_ready", 32'(in_ready), 32'b0001);
        @(negedge clk);
        out_ready = 1'b0; in_data[7:0] = 8'h66;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_data", i), 32'(out_data), 32'h5A);
            chk($sformatf("bp%0d_chan", i), 32'(out_chan), 32'd0);
            chk($sformatf("bp%0d_ready", i), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'b0001);
        chk("bp_release_data", 32'(out_data), 32'h5A);
        @(negedge clk); #1;
        chk("bp_next_data", 32'(out_data), 32'h66);
        chk("bp_next_valid", 32'(out_valid), 32'd1);

        // asynchronous reset between edges while full
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_chan", 32'(out_chan), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1; in_data = 32'h44332211;
        #1 chk("arst_first_ready", 32'(in_ready), 32'b0001);
        @(negedge clk); #1;
        chk("arst_first_valid", 32'(out_valid), 32'd1);
        chk("arst_first_chan", 32'(out_chan), 32'd0);
        chk("arst_first_data", 32'(out_data), 32'h11);
        in_valid = 4'h0;

        // N=3 with out-of-range sel
        @(negedge clk);
        m3 = 1'b0; s3 = 2'd3; v3 = 3'b111; or3 = 1'b1;
        #1 chk("n3_ready", 32'(r3), 32'd0);
`ifdef ARB_MUX_SEL_ERR_EN
        chk("n3_err_pre", 32'(se3), 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk($sformatf("n3_%0d_ready", i), 32'(r3), 32'd0);
            chk($sformatf("n3_%0d_valid", i), 32'(ov3), 32'd0);
`ifdef ARB_MUX_SEL_ERR_EN
            chk($sformatf("n3_%0d_err", i), 32'(se3), 32'd1);
`endif
        end
        s3 = 2'd2;
        #1 chk("n3_sel2_ready", 32'(r3), 32'b100);
        @(negedge clk); #1;
        chk("n3_sel2_chan", 32'(c3), 32'd2);
        chk("n3_sel2_data", 32'(od3), 32'h33);
`ifdef ARB_MUX_SEL_ERR_EN
        chk("n3_err_sticky", 32'(se3), 32'd1);
        rst = 1'b1;
        #1 chk("n3_err_rst", 32'(se3), 32'd0);
        rst = 1'b0;
`endif
        v3 = 3'b000;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
